// File: rtl/serial_word_receiver.sv
// Framed serial-to-parallel receiver: start(1) + WIDTH payload bits + stop(0), one bit per clock.
// Completed words are delivered through a one-deep valid/ready holding register.
module serial_word_receiver #(
  parameter int WIDTH     = 40,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sin,
  input  logic             ready,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             frame_err,
  output logic             overrun
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_STOP, S_RESYNC} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_shift_nxt;
  logic             w_start;
  logic             w_shift_en;
  logic             w_good_stop;
  logic             w_bad_stop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (sin) w_next = S_DATA;
      S_DATA:   if (r_cnt == LAST_BIT) w_next = S_STOP;
      S_STOP:   w_next = sin ? S_RESYNC : S_IDLE;
      // a high line here is the tail of a broken frame, never a new start bit
      S_RESYNC: if (!sin) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_start     = (r_state == S_IDLE) && sin;
    w_shift_en  = (r_state == S_DATA);
    w_good_stop = (r_state == S_STOP) && !sin;
    w_bad_stop  = (r_state == S_STOP) && sin;
  end

  always_comb begin
    if (MSB_FIRST) w_shift_nxt = {r_shift[WIDTH-2:0], sin};
    else           w_shift_nxt = {sin, r_shift[WIDTH-1:1]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_shift <= '0;
    end else begin
      if (w_start)         r_cnt <= '0;
      else if (w_shift_en) r_cnt <= r_cnt + 1'b1;
      if (w_shift_en)      r_shift <= w_shift_nxt;
    end
  end

  // A full holding register drops the new word; a same-edge handshake frees the slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= w_bad_stop;
      overrun   <= w_good_stop && valid && !ready;
      if (w_good_stop && (!valid || ready)) begin
        data  <= r_shift;
        valid <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_word_receiver.sv
// Bench for serial_word_receiver: 40-bit MSB-first instance checked through a word scoreboard,
// plus an 8-bit LSB-first instance checked directly.
module tb_serial_word_receiver;

  localparam int W  = 40;
  localparam int W8 = 8;
  localparam int K_OK   = 0;
  localparam int K_FERR = 1;
  localparam int K_OVR  = 2;

  logic          clk;
  logic          reset;
  logic          sin;
  logic          ready;
  logic [W-1:0]  data;
  logic          valid;
  logic          frame_err;
  logic          overrun;

  logic          sin8;
  logic [W8-1:0] data8;
  logic          valid8;
  logic          frame_err8;
  logic          overrun8;

  int n_checks = 0;
  int n_errors = 0;
  int exp_ferr = 0;
  int exp_ovr  = 0;
  int obs_ferr = 0;
  int obs_ovr  = 0;

  logic [W-1:0] sb_q[$];
  logic [W-1:0] sb_exp;
  logic         mon_prev_valid = 1'b0;
  logic         mon_rdy;
  logic         mon_vb;

  serial_word_receiver #(.WIDTH(W), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .reset(reset), .sin(sin), .ready(ready),
    .data(data), .valid(valid), .frame_err(frame_err), .overrun(overrun)
  );

  serial_word_receiver #(.WIDTH(W8), .MSB_FIRST(1'b0)) dut8 (
    .clk(clk), .reset(reset), .sin(sin8), .ready(ready),
    .data(data8), .valid(valid8), .frame_err(frame_err8), .overrun(overrun8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // New word visible when valid rises, or stays high across an accepted handshake
  always @(posedge clk) begin
    mon_rdy = ready;
    mon_vb  = mon_prev_valid;
    #1;
    if (!reset) begin
      if (valid && (!mon_vb || mon_rdy)) begin
        chk("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
        if (sb_q.size() != 0) begin
          sb_exp = sb_q.pop_front();
          chk("sb_data", 64'(data), 64'(sb_exp));
        end
      end
      if (frame_err) obs_ferr++;
      if (overrun)   obs_ovr++;
      if (frame_err || overrun) chk("err_excl", 64'(frame_err & overrun), 64'd0);
    end
    mon_prev_valid = valid;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      sin  = 1'b0;
      sin8 = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [W-1:0] w, input logic stop, input int kind,
                            input int stop_ready);
    if (kind == K_OK)        sb_q.push_back(w);
    else if (kind == K_FERR) exp_ferr++;
    else                     exp_ovr++;
    @(negedge clk); sin = 1'b1;
    for (int i = W - 1; i >= 0; i--) begin
      @(negedge clk); sin = w[i];
    end
    @(negedge clk); sin = stop;
    if (stop_ready >= 0) ready = stop_ready[0];
  endtask

  task automatic send_partial(input logic [W-1:0] w, input int nbits);
    @(negedge clk); sin = 1'b1;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk); sin = w[W-1-i];
    end
  endtask

  task automatic send8(input logic [W8-1:0] w, input int nbits);
    @(negedge clk); sin8 = 1'b1;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk); sin8 = w[i];
    end
    if (nbits == W8) begin
      @(negedge clk); sin8 = 1'b0;
    end
  endtask

  task automatic check_counts(input string tag);
    chk({tag, "_ferr_cnt"}, 64'(obs_ferr), 64'(exp_ferr));
    chk({tag, "_ovr_cnt"}, 64'(obs_ovr), 64'(exp_ovr));
    chk({tag, "_sb_drained"}, 64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    sin   = 1'b0;
    sin8  = 1'b0;
    ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_data", 64'(data), 64'd0);
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_ferr", 64'(frame_err), 64'd0);
    chk("rst_ovr", 64'(overrun), 64'd0);
    reset = 1'b0;
    idle(3);

    // single frame, ready=1: valid for exactly one cycle
    send_frame(40'hA9F0AAAAA9, 1'b0, K_OK, -1);
    @(posedge clk); #1;
    chk("t1_valid", 64'(valid), 64'd1);
    chk("t1_data", 64'(data), 64'hA9F0AAAAA9);
    @(posedge clk); #1;
    chk("t1_valid_drop", 64'(valid), 64'd0);
    chk("t1_data_held", 64'(data), 64'hA9F0AAAAA9);
    idle(2);
    check_counts("t1");

    // same word with 4 idle cycles, then with zero gap
    send_frame(40'hA9F0AAAAA9, 1'b0, K_OK, -1);
    idle(4);
    send_frame(40'hA9F0AAAAA9, 1'b0, K_OK, -1);
    send_frame(40'hA9F0AAAAA9, 1'b0, K_OK, -1);
    idle(3);
    check_counts("t2");

    // bad stop, line held high, then a good frame
    send_frame(40'h5555555555, 1'b1, K_FERR, -1);
    repeat (3) begin
      @(negedge clk); sin = 1'b1;
    end
    @(posedge clk); #1;
    chk("t3_no_valid", 64'(valid), 64'd0);
    idle(1);
    send_frame(40'h0000000001, 1'b0, K_OK, -1);
    idle(2);
    chk("t3_data", 64'(data), 64'h0000000001);
    check_counts("t3");

    // overrun with ready=0
    @(negedge clk); ready = 1'b0; sin = 1'b0;
    send_frame(40'h1234567890, 1'b0, K_OK, -1);
    idle(2);
    send_frame(40'hFFFFFFFFFF, 1'b0, K_OVR, -1);
    idle(3);
    chk("t4_data_kept", 64'(data), 64'h1234567890);
    chk("t4_valid", 64'(valid), 64'd1);
    @(negedge clk); ready = 1'b1;
    @(negedge clk); ready = 1'b0;
    #1;
    chk("t4_valid_drop", 64'(valid), 64'd0);
    check_counts("t4");

    // ready rises exactly at the stop edge while valid=1
    send_frame(40'h0F0F0F0F0F, 1'b0, K_OK, -1);
    idle(1);
    send_frame(40'hC3C3C3C3C3, 1'b0, K_OK, 1);
    @(posedge clk); #1;
    chk("t5_valid", 64'(valid), 64'd1);
    chk("t5_data", 64'(data), 64'hC3C3C3C3C3);
    @(negedge clk); ready = 1'b0; sin = 1'b0;
    idle(2);
    check_counts("t5");

    // asynchronous reset in the middle of a frame
    send_partial(40'hA9F0AAAAA9, 20);
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_data", 64'(data), 64'd0);
    chk("t6_rst_valid", 64'(valid), 64'd0);
    chk("t6_rst_ferr", 64'(frame_err), 64'd0);
    @(negedge clk); reset = 1'b0; sin = 1'b0; ready = 1'b1;
    idle(2);
    send_frame(40'hA9F0AAAAA9, 1'b0, K_OK, -1);
    idle(3);
    chk("t6_data", 64'(data), 64'hA9F0AAAAA9);
    check_counts("t6");

    // 8-bit LSB-first instance
    send8(8'hA5, W8);
    @(posedge clk); #1;
    chk("t7_a5_data", 64'(data8), 64'hA5);
    chk("t7_a5_valid", 64'(valid8), 64'd1);
    idle(2);
    send8(8'h3C, 4);
    #2 reset = 1'b1;
    #1;
    chk("t7_rst_data", 64'(data8), 64'd0);
    chk("t7_rst_valid", 64'(valid8), 64'd0);
    @(negedge clk); reset = 1'b0; sin8 = 1'b0;
    idle(2);
    send8(8'h01, W8);
    @(posedge clk); #1;
    chk("t7_data", 64'(data8), 64'h01);
    chk("t7_valid", 64'(valid8), 64'd1);
    chk("t7_errs", 64'({frame_err8, overrun8}), 64'd0);
    idle(3);
    check_counts("t7");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
